// File: rtl/bus_rr_sched_if.sv
// Bus bundle between the per-driver FIFOs and the round-robin scheduler.
// The master modport is the scheduler side; the slave modport is the FIFO/target side.
interface bus_rr_sched_if #(
  parameter int drvrs   = 16,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic                     busy;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, busy
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, busy
  );
endinterface

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler sharing one packet bus among drvrs FIFOs (IDLE -> POP -> PUSH).
// Optional macro BUS_SCHED_ERR_EN adds the err pulse port and a saturating err_cnt register.
module bus_rr_sched #(
  parameter int pckg_sz   = 16,
  parameter int drvrs     = 16,
  parameter int broadcast = 255
) (
  input  logic                clk,
  input  logic                reset,
  bus_rr_sched_if.master      bus
`ifdef BUS_SCHED_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state, state_d;
  logic [IW-1:0]      last, last_d;
  logic [IW-1:0]      src, src_d;
  logic [drvrs-1:0]   pop_d, push_d;
  logic [pckg_sz-1:0] dpush_d;
  logic               busy_d;
  logic               err_d;

  logic [IW-1:0]      rr_pick;
  logic               rr_hit;
  logic [pckg_sz-1:0] pkt;
  logic [7:0]         dest;
  int                 idx;

  // Scan starts at last+1 and wraps, so the previous winner is checked last.
  always_comb begin : arbiter
    rr_pick = last;
    rr_hit  = 1'b0;
    idx     = 0;
    for (int k = 1; k <= drvrs; k++) begin
      idx = int'(last) + k;
      if (idx >= drvrs) idx = idx - drvrs;
      if (!rr_hit && bus.pndng[IW'(idx)]) begin
        rr_hit  = 1'b1;
        rr_pick = IW'(idx);
      end
    end
  end

  always_comb begin : head_mux
    pkt = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (src == IW'(i)) pkt = bus.D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign dest = pkt[pckg_sz-1 -: 8];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin : fsm_next
    state_d = state;
    last_d  = last;
    src_d   = src;
    pop_d   = '0;
    push_d  = '0;
    dpush_d = bus.D_push;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_hit) begin
          state_d        = POP;
          src_d          = rr_pick;
          pop_d[rr_pick] = 1'b1;
          busy_d         = 1'b1;
        end
      end
      POP: begin
        state_d = PUSH;
        last_d  = src;
        dpush_d = pkt;
        busy_d  = 1'b1;
        if (int'(dest) < drvrs) begin
          for (int i = 0; i < drvrs; i++) push_d[i] = (int'(dest) == i);
        end else if (int'(dest) == broadcast) begin
          push_d      = '1;
          push_d[src] = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      PUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= IW'(drvrs - 1);
      src        <= '0;
      bus.pop    <= '0;
      bus.push   <= '0;
      bus.D_push <= '0;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_d;
      last       <= last_d;
      src        <= src_d;
      bus.pop    <= pop_d;
      bus.push   <= push_d;
      bus.D_push <= dpush_d;
      bus.busy   <= busy_d;
    end
  end

`ifdef BUS_SCHED_ERR_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= err_d;
      if (err_d && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: directed table, reset/corner sequences,
// and random traffic against a round-robin reference model.
module tb_bus_rr_sched;

  localparam int DRV = 4;
  localparam int PSZ = 16;
  localparam int BC  = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_rr_sched_if #(.drvrs(DRV), .pckg_sz(PSZ)) bus();

`ifdef BUS_SCHED_ERR_EN
  logic err;
`endif

  bus_rr_sched #(.pckg_sz(PSZ), .drvrs(DRV), .broadcast(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BUS_SCHED_ERR_EN
    ,
    .err   (err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err_cnt = 0;

  typedef struct {
    logic [3:0]  pndng;
    logic [63:0] dpop;
    int          src;
    logic [3:0]  push;
    logic [15:0] dpush;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Caller is just past a clock edge with the DUT idle; leaves it idle again.
  task automatic run_txn(input string tag, input logic [3:0] pndng_v, input logic [63:0] dpop_v,
                         input int exp_src, input logic [3:0] exp_push,
                         input logic [15:0] exp_dpush, input logic exp_err);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_src;
    if (exp_err) exp_err_cnt++;
    bus.pndng = pndng_v;
    bus.D_pop = dpop_v;
    @(posedge clk); #1;
    bus.pndng = '0;  // granted source must still be popped after dropping pndng
    check($sformatf("%s pop", tag), bus.pop, onehot);
    check($sformatf("%s busy_pop", tag), bus.busy, 1'b1);
    check($sformatf("%s push_pop", tag), bus.push, 4'b0000);
    @(posedge clk); #1;
    check($sformatf("%s push", tag), bus.push, exp_push);
    check($sformatf("%s D_push", tag), bus.D_push, exp_dpush);
    check($sformatf("%s pop_push", tag), bus.pop, 4'b0000);
    check($sformatf("%s busy_push", tag), bus.busy, 1'b1);
`ifdef BUS_SCHED_ERR_EN
    check($sformatf("%s err", tag), err, exp_err);
`endif
    @(posedge clk); #1;
    check($sformatf("%s push_idle", tag), bus.push, 4'b0000);
    check($sformatf("%s busy_idle", tag), bus.busy, 1'b0);
`ifdef BUS_SCHED_ERR_EN
    check($sformatf("%s err_idle", tag), err, 1'b0);
`endif
  endtask

  initial begin
    int          m_last;
    logic [3:0]  pv, mpush;
    logic [63:0] dv;
    logic [15:0] pk [4];
    int          win, r;
    logic [7:0]  d;

    vecs[0] = '{4'b1111, {16'h0000, 16'h0300, 16'h0200, 16'h0100}, 0, 4'b0010, 16'h0100, 1'b0};
    vecs[1] = '{4'b1111, {16'h0000, 16'h0300, 16'h0200, 16'h0100}, 1, 4'b0100, 16'h0200, 1'b0};
    vecs[2] = '{4'b1111, {16'h0000, 16'h0300, 16'h0200, 16'h0100}, 2, 4'b1000, 16'h0300, 1'b0};
    vecs[3] = '{4'b1111, {16'h0000, 16'h0300, 16'h0200, 16'h0100}, 3, 4'b0001, 16'h0000, 1'b0};
    vecs[4] = '{4'b1111, {16'h0000, 16'h0300, 16'h0200, 16'h0100}, 0, 4'b0010, 16'h0100, 1'b0};
    vecs[5] = '{4'b0100, {16'h0000, 16'hFF5A, 16'h0000, 16'h0000}, 2, 4'b1011, 16'hFF5A, 1'b0};
    vecs[6] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0711}, 0, 4'b0000, 16'h0711, 1'b1};
    vecs[7] = '{4'b1000, {16'h03C3, 16'h0000, 16'h0000, 16'h0000}, 3, 4'b1000, 16'h03C3, 1'b0};
    vecs[8] = '{4'b1010, {16'h0166, 16'h0000, 16'h0055, 16'h0000}, 1, 4'b0001, 16'h0055, 1'b0};
    vecs[9] = '{4'b1010, {16'h0166, 16'h0000, 16'h0055, 16'h0000}, 3, 4'b0010, 16'h0166, 1'b0};

    bus.pndng = '0;
    bus.D_pop = '0;
    #1;
    check("rst pop", bus.pop, 4'b0000);
    check("rst push", bus.push, 4'b0000);
    check("rst D_push", bus.D_push, 16'h0000);
    check("rst busy", bus.busy, 1'b0);
`ifdef BUS_SCHED_ERR_EN
    check("rst err", err, 1'b0);
    check("rst err_cnt", dut.err_cnt, 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_txn("single", 4'b0010, {16'h0000, 16'h0000, 16'h02AB, 16'h0000}, 1, 4'b0100, 16'h02AB, 1'b0);

    // Reset landing in the POP cycle must discard the packet.
    bus.pndng = 4'b0100;
    bus.D_pop = {16'h0000, 16'h0011, 16'h0000, 16'h0000};
    @(posedge clk); #1;
    check("rstmid pop_before", bus.pop, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("rstmid pop_async", bus.pop, 4'b0000);
    check("rstmid busy_async", bus.busy, 1'b0);
    check("rstmid push_async", bus.push, 4'b0000);
    @(posedge clk); #1;
    check("rstmid push_held", bus.push, 4'b0000);
    check("rstmid D_push", bus.D_push, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    bus.pndng = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid no_push", bus.push, 4'b0000);
      check("rstmid no_pop", bus.pop, 4'b0000);
    end

    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].pndng, vecs[i].dpop, vecs[i].src,
              vecs[i].push, vecs[i].dpush, vecs[i].err);

    // Random traffic; model tracks only the last winner and derives the rest from the rules.
    m_last = 3;
    for (int t = 0; t < 150; t++) begin
      pv = 4'($urandom_range(1, 15));
      for (int i = 0; i < DRV; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      d = 8'(r % DRV);
        else if (r < 8) d = 8'(BC);
        else            d = 8'($urandom_range(DRV, BC - 1));
        pk[i] = {d, 8'($urandom_range(0, 255))};
      end
      dv = {pk[3], pk[2], pk[1], pk[0]};
      win = -1;
      for (int k = 1; k <= DRV; k++)
        if (win < 0 && pv[(m_last + k) % DRV]) win = (m_last + k) % DRV;
      d = pk[win][15:8];
      if (d < DRV)      mpush = 4'b0001 << d;
      else if (d == BC) mpush = 4'b1111 & ~(4'b0001 << win);
      else              mpush = 4'b0000;
      run_txn($sformatf("rnd%0d", t), pv, dv, win, mpush, pk[win],
              (d >= DRV) && (d != BC));
      m_last = win;
    end

`ifdef BUS_SCHED_ERR_EN
    check("err_cnt", dut.err_cnt, 64'(exp_err_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_sched.md
# bus_rr_sched

Round-robin bus scheduler that shares a single packet bus among `drvrs` driver FIFOs. It sits between the per-driver FIFO interfaces (`pndng`/`pop`/`D_pop`) and the shared bus output (`push`/`D_push`). It picks one pending source per transaction, pops its head packet, and decodes the destination field. It then pushes the packet to one target, or to all targets except the source on the broadcast address.

## Interface
- `pckg_sz`, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID, the rest is payload
- `drvrs`, 16, number of driver FIFOs/targets (2..255)
- `broadcast`, 255, destination ID meaning "all targets"
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, asynchronous and active-high
- `pndng`  in  drvrs  bit i = FIFO i holds at least one packet; head packet valid on its `D_pop` slice
- `D_pop`  in  drvrs*pckg_sz  head packets; slice i = [i*pckg_sz +: pckg_sz]
- `pop`  out  drvrs  one-hot, 1-cycle pop strobe to the granted FIFO
- `push`  out  drvrs  push strobe per target; one-hot for unicast, multi-hot for broadcast
- `D_push`  out  pckg_sz  packet on the bus; valid while any `push` bit is high
- `busy`  out  1  high in every state other than IDLE
- `err`  out  1  1-cycle pulse on an invalid destination (present only with `BUS_SCHED_ERR_EN`)

## Operation
- FSM states: IDLE, POP, PUSH. All outputs are registered.
- **IDLE:**
  - If `pndng` != 0, select the source with round-robin priority and go to POP.
  - The first candidate is `last+1`. The search wraps modulo `drvrs`.
  - Otherwise stay in IDLE.
- **POP:**
  - Assert `pop[src]` for this cycle only.
  - Capture the `D_pop` slice for `src` into the packet register.
  - Update `last` to `src`.
  - Go to PUSH.
- **PUSH:**
  - Drive `D_push` with the captured packet.
  - If dest < `drvrs`, assert `push[dest]` (one-hot). dest == src is delivered to src.
  - If dest == `broadcast`, assert `push` = all ones with bit `src` cleared.
  - Any other dest is invalid: `push` stays 0 and the packet is dropped.
  - Go to IDLE.
- Only the granted source is affected by a transaction. Other `pndng` bits stay pending until they win arbitration.
- A source cannot win twice in a row while any other source is pending, so starvation is bounded at `drvrs` transactions.

## Timing
- Reset values:
  - State is IDLE.
  - `last` = `drvrs-1`, so driver 0 has first priority.
  - `pop` = 0, `push` = 0, `D_push` = 0, `busy` = 0, `err` = 0.
- Pipeline: `pndng` seen in IDLE at edge n. `pop` is high in cycle n+1. `push`/`D_push` are high in cycle n+2. The FSM is back in IDLE at n+3.
- Throughput: one packet per 3 cycles.
- `D_push` holds its value after PUSH until the next PUSH. Only the `push` bits qualify it.
- `pndng` is sampled only in IDLE. A source that deasserts `pndng` after being selected is still popped.
- Simultaneous requests are resolved purely by round-robin order from `last+1`.
- Reset asserted in any state:
  - Outputs go to their reset values immediately (asynchronous).
  - The in-flight packet is discarded and no partial `push` occurs.
  - After reset deasserts, the FSM returns to IDLE on the next edge.

## Configuration
- `BUS_SCHED_ERR_EN` defined:
  - The `err` port exists.
  - `err` pulses high in the PUSH cycle of any packet with an invalid destination.
  - A saturating 16-bit `err_cnt` register counts these events. It resets to 0 and is readable by hierarchy.
- `BUS_SCHED_ERR_EN` undefined:
  - No `err` port and no counter.
  - Invalid packets are silently dropped with the same 3-cycle timing.

## Test plan
Parameters for all scenarios: drvrs=4, pckg_sz=16, broadcast=255.
- **Single unicast:** `pndng`=4'b0010, D_pop[1]=16'h02AB. Required: `pop`=4'b0010 at n+1; `push`=4'b0100 and `D_push`=16'h02AB at n+2; `busy` high for 2 cycles.
- **Round-robin fairness:** `pndng`=4'b1111 held for 4 transactions after reset. Required: `pop` grant order is 0,1,2,3; driver 0 is granted again on the 5th transaction.
- **Broadcast:** source 2 holds 16'hFF5A. Required: `push`=4'b1011 and `D_push`=16'hFF5A in the PUSH cycle.
- **Invalid destination:** source 0 holds 16'h0711. Required: `push` stays 0; with `BUS_SCHED_ERR_EN`, `err`=1 for one cycle and `err_cnt`=1.
- **Reset mid-transaction:** assert `reset` during the POP cycle. Required: `pop`/`push` go to 0 at once; no push follows; after release, source 0 wins first.
- **Self-addressed:** source 3 holds 16'h03C3. Required: `push`=4'b1000 and `D_push`=16'h03C3.
